// File: rtl/alu_seq_if.sv
`default_nettype none
// ============================================================================
//  Module   : alu_seq_if
//  Purpose  : Request/result bundle between the datapath control and alu_seq.
//             The master drives operands, select and start; the slave returns
//             the registered result, flags and the busy/done handshake.
//  Revision : 1.0  initial release
// ============================================================================
interface alu_seq_if #(
  parameter int WIDTH = 5
);
  logic             start;
  logic [WIDTH-1:0] inp_A;
  logic [WIDTH-1:0] inp_B;
  logic [2:0]       select;
  logic [WIDTH-1:0] out;
  logic [WIDTH-1:0] out_hi;
  logic             carry;
  logic             zero;
  logic             busy;
  logic             done;

  modport master (
    output start, inp_A, inp_B, select,
    input  out, out_hi, carry, zero, busy, done
  );

  modport slave (
    input  start, inp_A, inp_B, select,
    output out, out_hi, carry, zero, busy, done
  );
endinterface
`default_nettype wire

// File: rtl/alu_seq.sv
`default_nettype none
// ============================================================================
//  Module   : alu_seq
//  Purpose  : Registered ALU (AND/ADD/OR/XOR/SUB/SLT) with a multi-cycle
//             unsigned shift-add multiplier, carry/zero flags and a
//             start/busy/done handshake. Select codes 0-3 keep the legacy
//             meaning of the old combinational unit.
//  Revision : 1.0  initial release
// ============================================================================
module alu_seq #(
  parameter int WIDTH = 5
) (
  input  logic     clk,
  input  logic     reset,
  alu_seq_if.slave bus
);

  localparam int CNT_W = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

  localparam logic [2:0] OP_AND = 3'b000;
  localparam logic [2:0] OP_ADD = 3'b001;
  localparam logic [2:0] OP_OR  = 3'b010;
  localparam logic [2:0] OP_XOR = 3'b011;
  localparam logic [2:0] OP_SUB = 3'b100;
  localparam logic [2:0] OP_SLT = 3'b101;
  localparam logic [2:0] OP_MUL = 3'b110;

  typedef enum logic [0:0] {
    IDLE    = 1'b0,
    MUL_RUN = 1'b1
  } state_t;

  state_t             state_q;
  logic [WIDTH-1:0]   out_q;
  logic [WIDTH-1:0]   out_hi_q;
  logic               carry_q;
  logic               zero_q;
  logic               busy_q;
  logic               done_q;

  // Multiplier working registers: the multiplicand is kept pre-shifted by the
  // iteration count and the multiplier is consumed LSB first, so each step
  // only needs bit 0 and a plain add.
  logic [2*WIDTH-1:0] acc_q;
  logic [2*WIDTH-1:0] mcand_q;
  logic [WIDTH-1:0]   mplier_q;
  logic [CNT_W-1:0]   cnt_q;

  logic [WIDTH-1:0]   alu_res_d;
  logic               alu_carry_d;
  logic [WIDTH:0]     add_ext_d;
  logic [2*WIDTH-1:0] acc_d;

  // Single-cycle result and carry straight from the live operands
  always_comb begin
    add_ext_d   = {1'b0, bus.inp_A} + {1'b0, bus.inp_B};
    alu_res_d   = '0;
    alu_carry_d = 1'b0;
    case (bus.select)
      OP_AND: alu_res_d = bus.inp_A & bus.inp_B;
      OP_ADD: begin
        alu_res_d   = add_ext_d[WIDTH-1:0];
        alu_carry_d = add_ext_d[WIDTH];
      end
      OP_OR:  alu_res_d = bus.inp_A | bus.inp_B;
      OP_XOR: alu_res_d = bus.inp_A ^ bus.inp_B;
      OP_SUB: begin
        alu_res_d   = bus.inp_A - bus.inp_B;
        alu_carry_d = (bus.inp_A >= bus.inp_B);
      end
      OP_SLT: alu_res_d = {{(WIDTH-1){1'b0}},
                           ($signed(bus.inp_A) < $signed(bus.inp_B))};
      // MUL is not computed here; 111 is reserved and yields all zeros
      default: begin
        alu_res_d   = '0;
        alu_carry_d = 1'b0;
      end
    endcase
  end

  // Accumulator value after the current shift-add iteration
  always_comb begin
    acc_d = acc_q + (mplier_q[0] ? mcand_q : '0);
  end

  // Control FSM plus all registered outputs and multiplier datapath
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      out_q    <= '0;
      out_hi_q <= '0;
      carry_q  <= 1'b0;
      zero_q   <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      acc_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      cnt_q    <= '0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (bus.start) begin
            if (bus.select == OP_MUL) begin
              acc_q    <= '0;
              mcand_q  <= {{WIDTH{1'b0}}, bus.inp_A};
              mplier_q <= bus.inp_B;
              cnt_q    <= '0;
              busy_q   <= 1'b1;
              state_q  <= MUL_RUN;
            end else begin
              out_q    <= alu_res_d;
              out_hi_q <= '0;
              carry_q  <= alu_carry_d;
              zero_q   <= (alu_res_d == '0);
              done_q   <= 1'b1;
            end
          end
        end
        MUL_RUN: begin
          acc_q    <= acc_d;
          mcand_q  <= mcand_q << 1;
          mplier_q <= mplier_q >> 1;
          cnt_q    <= cnt_q + 1'b1;
          // The last iteration publishes the product directly, so the
          // result lands on the same edge that drops busy.
          if (cnt_q == LAST_CNT) begin
            out_q    <= acc_d[WIDTH-1:0];
            out_hi_q <= acc_d[2*WIDTH-1:WIDTH];
            carry_q  <= (acc_d[2*WIDTH-1:WIDTH] != '0);
            zero_q   <= (acc_d == '0);
            done_q   <= 1'b1;
            busy_q   <= 1'b0;
            state_q  <= IDLE;
          end
        end
        default: begin
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign bus.out    = out_q;
  assign bus.out_hi = out_hi_q;
  assign bus.carry  = carry_q;
  assign bus.zero   = zero_q;
  assign bus.busy   = busy_q;
  assign bus.done   = done_q;

endmodule
`default_nettype wire
